// File: rtl/delay_tap_sweep.sv
// Sweeps a delay-line tap from tap_lo to tap_hi. At each tap it waits SETTLE cycles, then
// accumulates popcount(sample_in) over SAMPLES cycles and offers the total through a
// valid/ready handshake.
module delay_tap_sweep #(
    parameter int unsigned SENSE_W = 8,
    parameter int unsigned SAMPLES = 16,
    parameter int unsigned SETTLE  = 4,
    localparam int unsigned OnesW  = $clog2(SAMPLES * SENSE_W) + 1
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               start,
    input  logic [4:0]         tap_lo,
    input  logic [4:0]         tap_hi,
    input  logic [SENSE_W-1:0] sample_in,
    output logic [4:0]         delay,
    output logic               busy,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [4:0]         result_tap,
    output logic [OnesW-1:0]   result_ones,
    output logic               done,
    output logic               range_err
);

    localparam int unsigned CntW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam logic [7:0]      SettleLast = 8'(SETTLE - 1);
    localparam logic [CntW-1:0] SampLast   = CntW'(SAMPLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StAccum, StReport} state_t;

    state_t            r_state;
    logic [4:0]        r_delay;
    logic [4:0]        r_tap_hi;
    logic [7:0]        r_settle_cnt;
    logic [CntW-1:0]   r_samp_cnt;
    logic [OnesW-1:0]  r_acc;
    logic              r_busy;
    logic              r_valid;
    logic [4:0]        r_res_tap;
    logic [OnesW-1:0]  r_res_ones;
    logic              r_done;
    logic              r_range_err;
    logic [OnesW-1:0]  w_pop;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < int'(SENSE_W); i++) begin
            w_pop = w_pop + OnesW'(sample_in[i]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state      <= StIdle;
            r_delay      <= '0;
            r_tap_hi     <= '0;
            r_settle_cnt <= '0;
            r_samp_cnt   <= '0;
            r_acc        <= '0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_res_tap    <= '0;
            r_res_ones   <= '0;
            r_done       <= 1'b0;
            r_range_err  <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_range_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        if (tap_lo <= tap_hi) begin
                            r_state      <= StSettle;
                            r_delay      <= tap_lo;
                            r_tap_hi     <= tap_hi;
                            r_settle_cnt <= '0;
                            r_samp_cnt   <= '0;
                            r_acc        <= '0;
                            r_busy       <= 1'b1;
                        end else begin
                            r_done      <= 1'b1;
                            r_range_err <= 1'b1;
                        end
                    end
                end
                StSettle: begin
                    if (r_settle_cnt == SettleLast) begin
                        r_state      <= StAccum;
                        r_settle_cnt <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 8'd1;
                    end
                end
                StAccum: begin
                    r_acc <= r_acc + w_pop;
                    if (r_samp_cnt == SampLast) begin
                        // Capture the result with the final sample folded in.
                        r_state    <= StReport;
                        r_samp_cnt <= '0;
                        r_valid    <= 1'b1;
                        r_res_tap  <= r_delay;
                        r_res_ones <= r_acc + w_pop;
                    end else begin
                        r_samp_cnt <= r_samp_cnt + CntW'(1);
                    end
                end
                StReport: begin
                    if (result_ready) begin
                        r_valid <= 1'b0;
                        if (r_delay == r_tap_hi) begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= StSettle;
                            r_delay      <= r_delay + 5'd1;
                            r_acc        <= '0;
                            r_settle_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign delay        = r_delay;
    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign result_tap   = r_res_tap;
    assign result_ones  = r_res_ones;
    assign done         = r_done;
    assign range_err    = r_range_err;

endmodule

// File: tb/tb_delay_tap_sweep.sv
// Bench for delay_tap_sweep: a cycle-timing model compared on every negedge, plus
// directed sweeps with hand-computed literal expectations.
module tb_delay_tap_sweep;

    localparam int SENSE_W = 8;
    localparam int SAMPLES = 16;
    localparam int SETTLE  = 4;
    localparam int OW      = $clog2(SAMPLES * SENSE_W) + 1;

    logic               clk_in = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [4:0]         tap_lo = '0;
    logic [4:0]         tap_hi = '0;
    logic [SENSE_W-1:0] sample_in = '0;
    logic [4:0]         delay;
    logic               busy;
    logic               result_valid;
    logic               result_ready = 1'b1;
    logic [4:0]         result_tap;
    logic [OW-1:0]      result_ones;
    logic               done;
    logic               range_err;

    delay_tap_sweep #(.SENSE_W(SENSE_W), .SAMPLES(SAMPLES), .SETTLE(SETTLE)) dut (
        .clk_in(clk_in), .rst(rst), .start(start), .tap_lo(tap_lo), .tap_hi(tap_hi),
        .sample_in(sample_in), .delay(delay), .busy(busy), .result_valid(result_valid),
        .result_ready(result_ready), .result_tap(result_tap), .result_ones(result_ones),
        .done(done), .range_err(range_err)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timing model: a tap entered at cycle E reports from cycle E+SETTLE+SAMPLES onward.
    int  cyc = 0;
    bit  m_active = 0;
    bit  m_after_rst = 1;
    int  m_delay = 0;
    int  m_hi = 0;
    int  m_enter = 0;
    int  m_acc = 0;
    int  m_done_at = -1;
    int  m_rerr_at = -1;
    int  m_accept_cyc = -1;
    int  last_start_cyc = -1;

    // Observations of the DUT for the directed checks.
    int  got_tap[$];
    int  got_ones[$];
    int  done_cnt = 0;
    int  done_cyc = -1;
    int  hs_cyc = -1;
    int  first_valid = -1;
    bit  busy_seen = 0;
    bit  valid_seen = 0;
    bit  rerr_seen = 0;
    bit  rnd_samp = 0;

    always @(negedge clk_in) begin
        bit exp_valid;
        cyc++;
        exp_valid = m_active && (cyc >= m_enter + SETTLE + SAMPLES);
        chk("valid", int'(result_valid), int'(exp_valid));
        chk("busy", int'(busy), int'(m_active));
        chk("done", int'(done), int'(cyc == m_done_at));
        chk("range_err", int'(range_err), int'(cyc == m_rerr_at));
        chk("delay", int'(delay), m_delay);
        if (m_after_rst) begin
            chk("rst_result_tap", int'(result_tap), 0);
            chk("rst_result_ones", int'(result_ones), 0);
        end
        if (exp_valid && result_valid) begin
            chk("result_tap", int'(result_tap), m_delay);
            chk("result_ones", int'(result_ones), m_acc);
        end

        if (busy) busy_seen = 1;
        if (result_valid) valid_seen = 1;
        if (range_err) rerr_seen = 1;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (result_valid && first_valid < 0) first_valid = cyc;
        if (result_valid && result_ready && !rst) begin
            got_tap.push_back(int'(result_tap));
            got_ones.push_back(int'(result_ones));
            hs_cyc = cyc;
        end

        if (rst) begin
            m_active    = 0;
            m_delay     = 0;
            m_after_rst = 1;
            m_done_at   = -1;
            m_rerr_at   = -1;
        end else begin
            m_after_rst = 0;
            if (!m_active) begin
                if (start) begin
                    last_start_cyc = cyc;
                    if (tap_lo <= tap_hi) begin
                        m_active     = 1;
                        m_delay      = int'(tap_lo);
                        m_hi         = int'(tap_hi);
                        m_enter      = cyc + 1;
                        m_acc        = 0;
                        m_accept_cyc = cyc;
                    end else begin
                        m_done_at = cyc + 1;
                        m_rerr_at = cyc + 1;
                    end
                end
            end else begin
                if (cyc >= m_enter + SETTLE && cyc < m_enter + SETTLE + SAMPLES)
                    m_acc += $countones(sample_in);
                if (exp_valid && result_ready) begin
                    if (m_delay == m_hi) begin
                        m_active  = 0;
                        m_done_at = cyc + 1;
                    end else begin
                        m_delay++;
                        m_enter = cyc + 1;
                        m_acc   = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (rnd_samp) sample_in = SENSE_W'($urandom);
    endtask

    task automatic clear_log();
        got_tap.delete();
        got_ones.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        hs_cyc      = -1;
        first_valid = -1;
        busy_seen   = 0;
        valid_seen  = 0;
        rerr_seen   = 0;
    endtask

    task automatic pulse_start(input int lo, input int hi);
        start  = 1'b1;
        tap_lo = 5'(lo);
        tap_hi = 5'(hi);
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 3000 && done_cnt == 0; i++) tick();
        if (done_cnt == 0) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        result_ready = 1'b1;
        repeat (3) tick();
        chk("reset_delay", int'(delay), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(result_valid), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ones", int'(result_ones), 0);
        rst = 1'b0;
        tick();

        // Three taps, 4 ones per word over 16 words.
        clear_log();
        sample_in = 8'h0F;
        pulse_start(3, 5);
        wait_done("t1");
        tick();
        chk("t1_count", got_tap.size(), 3);
        for (int i = 0; i < 3 && i < got_tap.size(); i++) begin
            chk("t1_tap", got_tap[i], 3 + i);
            chk("t1_ones", got_ones[i], 64);
        end
        chk("t1_latency", first_valid - m_accept_cyc, 21);
        chk("t1_done_after_hs", done_cyc - hs_cyc, 1);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_final_delay", int'(delay), 5);

        // Single-tap sweep.
        clear_log();
        sample_in = 8'hFF;
        pulse_start(10, 10);
        wait_done("t2");
        tick();
        chk("t2_count", got_tap.size(), 1);
        if (got_tap.size() > 0) begin
            chk("t2_tap", got_tap[0], 10);
            chk("t2_ones", got_ones[0], 128);
        end
        chk("t2_done_cnt", done_cnt, 1);

        // Inverted range is rejected.
        clear_log();
        pulse_start(7, 2);
        wait_done("t3");
        repeat (3) tick();
        chk("t3_done_cycle", done_cyc - last_start_cyc, 1);
        chk("t3_range_err", int'(rerr_seen), 1);
        chk("t3_busy_seen", int'(busy_seen), 0);
        chk("t3_valid_seen", int'(valid_seen), 0);
        chk("t3_delay_kept", int'(delay), 10);

        // Stall at the top of the tap range; no wrap past 31.
        clear_log();
        sample_in    = 8'h03;
        result_ready = 1'b0;
        pulse_start(30, 31);
        for (int i = 0; i < 100 && !result_valid; i++) tick();
        for (int i = 0; i < 10; i++) begin
            chk("t4_stall_valid", int'(result_valid), 1);
            chk("t4_stall_tap", int'(result_tap), 30);
            chk("t4_stall_delay", int'(delay), 30);
            tick();
        end
        result_ready = 1'b1;
        wait_done("t4");
        tick();
        chk("t4_count", got_tap.size(), 2);
        if (got_tap.size() == 2) begin
            chk("t4_tap0", got_tap[0], 30);
            chk("t4_tap1", got_tap[1], 31);
            chk("t4_ones", got_ones[1], 32);
        end
        chk("t4_final_delay", int'(delay), 31);

        // Reset in the middle of accumulating tap 4.
        clear_log();
        sample_in = 8'h55;
        pulse_start(3, 6);
        for (int i = 0; i < 100 && delay != 5'd4; i++) tick();
        repeat (SETTLE + 3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_delay", int'(delay), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_valid", int'(result_valid), 0);
        chk("t5_rst_tap", int'(result_tap), 0);
        chk("t5_rst_ones", int'(result_ones), 0);
        chk("t5_results_before_rst", got_tap.size(), 1);
        valid_seen = 0;
        repeat (30) tick();
        chk("t5_no_result_after_rst", int'(valid_seen), 0);
        clear_log();
        sample_in = 8'hA5;
        pulse_start(0, 0);
        wait_done("t5");
        tick();
        chk("t5_count", got_tap.size(), 1);
        if (got_tap.size() > 0) begin
            chk("t5_tap", got_tap[0], 0);
            chk("t5_ones", got_ones[0], 64);
        end

        // Second start mid-sweep is ignored; random samples exercise accumulation.
        clear_log();
        rnd_samp = 1;
        pulse_start(1, 2);
        repeat (10) tick();
        pulse_start(20, 25);
        tap_lo = 5'd0;
        tap_hi = 5'd31;
        wait_done("t6");
        tick();
        rnd_samp = 0;
        chk("t6_count", got_tap.size(), 2);
        if (got_tap.size() == 2) begin
            chk("t6_tap0", got_tap[0], 1);
            chk("t6_tap1", got_tap[1], 2);
        end
        chk("t6_done_cnt", done_cnt, 1);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/delay_tap_sweep.md
DELAY_TAP_SWEEP -- requirements
Module: delay_tap_sweep

Interface
REQ-001 Parameter SENSE_W, default 8: width of the sensor capture word sampled by the delayed clock.
REQ-002 Parameter SAMPLES, default 16: capture words accumulated per tap; power of two, 2..256.
REQ-003 Parameter SETTLE, default 4: cycles waited after each tap change before accumulating; 1..255.
REQ-004 clk_in  input  1  sole clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-007 tap_lo  input  5  first tap of sweep; captured on accepted start.
REQ-008 tap_hi  input  5  last tap of sweep; captured on accepted start.
REQ-009 sample_in  input  SENSE_W  sensor capture word, already synchronous to clk_in.
REQ-010 delay  output  5  tap value driven to the runtime delay line.
REQ-011 busy  output  1  high from the cycle after accepted start until the cycle done pulses.
REQ-012 result_valid  output  1  result available; held until accepted.
REQ-013 result_ready  input  1  downstream accepts the result when high with result_valid.
REQ-014 result_tap  output  5  tap the result belongs to.
REQ-015 result_ones  output  log2(SAMPLES*SENSE_W)+1  total ones counted across SAMPLES words at result_tap.
REQ-016 done  output  1  one-cycle pulse at sweep end.
REQ-017 range_err  output  1  one-cycle pulse, with done, when tap_lo > tap_hi.

Function
REQ-018 States SHALL be IDLE, SETTLE, ACCUM, REPORT; the only transitions are those below.
REQ-019 IDLE: on start=1 with tap_lo <= tap_hi -> SETTLE; next cycle delay=tap_lo, settle counter=0, accumulator=0, busy=1.
REQ-020 IDLE: on start=1 with tap_lo > tap_hi -> stay IDLE; next cycle done=1, range_err=1, delay unchanged, no result produced.
REQ-021 SETTLE: occupies exactly SETTLE cycles, then -> ACCUM; sample_in ignored.
REQ-022 ACCUM: occupies exactly SAMPLES cycles; each cycle adds popcount(sample_in) to the accumulator; then -> REPORT.
REQ-023 Accumulator width equals result_ones width; it never overflows (max SAMPLES*SENSE_W).
REQ-024 REPORT: result_valid=1, result_tap=current delay, result_ones=final accumulator; all three stable until handshake.
REQ-025 Handshake completes on the cycle result_valid=1 and result_ready=1; result_valid low the following cycle.
REQ-026 After handshake with delay < captured tap_hi: next cycle delay=delay+1, accumulator=0, state SETTLE.
REQ-027 After handshake with delay == captured tap_hi: next cycle state IDLE, done=1, busy=0; delay holds last tap.
REQ-028 tap_hi=31 SHALL end the sweep at 31 with no wrap to 0.
REQ-029 tap_lo == tap_hi SHALL produce exactly one result.
REQ-030 Latency: start accepted at cycle 0 -> first result_valid at cycle SETTLE+SAMPLES+1 (21 with defaults), given no stall.
REQ-031 start asserted while busy SHALL be ignored; tap_lo/tap_hi changes after acceptance SHALL have no effect.
REQ-032 result_ready held low stalls indefinitely in REPORT; delay SHALL not change while stalled.
REQ-033 delay SHALL change only on entry to SETTLE, never during ACCUM or REPORT.

Reset
REQ-034 rst=1 at any cycle, including mid-sweep, SHALL on the next edge force IDLE, delay=0, busy=0, result_valid=0, result_tap=0, result_ones=0, done=0, range_err=0, accumulator and counters=0.
REQ-035 rst has priority over start and handshake in the same cycle; no partial result is reported after reset.

Verification
REQ-036 Defaults, tap_lo=3, tap_hi=5, sample_in=8'h0F constant, result_ready=1 -> three results, taps 3,4,5, each result_ones=64; first valid at cycle 21; done one cycle after third handshake.
REQ-037 tap_lo=10, tap_hi=10, sample_in=8'hFF -> single result tap 10, result_ones=128; done pulses once.
REQ-038 tap_lo=7, tap_hi=2 -> done=1 and range_err=1 on cycle 1, busy never high, result_valid never high.
REQ-039 tap_lo=30, tap_hi=31, result_ready low for 10 cycles at first result -> result_valid, result_tap=30, delay=30 held stable throughout stall; second result tap 31; no wrap.
REQ-040 rst asserted during ACCUM of tap 4 (sweep 3..6) -> next cycle all outputs at reset values; new start with tap_lo=0, tap_hi=0 then completes normally.
REQ-041 start pulsed again mid-sweep with different tap_lo/tap_hi -> ignored; original sweep's result taps and count unchanged.
